// File: rtl/matvec_mac.sv
// Fixed-point matrix-vector multiply-accumulate engine.
// Streams one weight row per output neuron and emits saturated results.
module matvec_mac #(
  parameter int IN_DIM    = 784,
  parameter int OUT_DIM   = 5,
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] weight_addr,
  input  logic [31:0] weight_data,
  output logic [15:0] input_addr,
  input  logic [31:0] input_data,
  output logic        out_valid,
  output logic [15:0] out_index,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_LAST_I = 16'(IN_DIM - 1);
  localparam logic [15:0] LP_LAST_O = 16'(OUT_DIM - 1);
  localparam logic [15:0] LP_STEP   = 16'(IN_DIM);

  localparam logic signed [63:0] LP_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] LP_MIN = 64'shFFFF_FFFF_8000_0000;

  state_t             r_state;
  logic        [15:0] r_i;
  logic        [15:0] r_o;
  logic        [15:0] r_base;
  logic signed [63:0] r_acc;
  logic               r_out_valid;
  logic        [15:0] r_out_index;
  logic        [31:0] r_out_data;
  logic               r_busy;
  logic               r_done;

  logic               w_in_mac;
  logic signed [63:0] w_wd;
  logic signed [63:0] w_id;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_acc_next;
  logic signed [63:0] w_shift;
  logic        [31:0] w_sat;

  assign w_in_mac = (r_state == S_MAC);

  // Row base is stepped by IN_DIM so addressing needs only an adder.
  assign weight_addr = w_in_mac ? (r_base + r_i) : 16'h0;
  assign input_addr  = w_in_mac ? r_i : 16'h0;

  assign w_wd       = {{32{weight_data[31]}}, weight_data};
  assign w_id       = {{32{input_data[31]}}, input_data};
  assign w_prod     = w_wd * w_id;
  assign w_acc_next = r_acc + w_prod;
  assign w_shift    = w_acc_next >>> FRAC_BITS;

  always_comb begin
    w_sat = w_shift[31:0];
    if (w_shift > LP_MAX) begin
      w_sat = 32'h7FFF_FFFF;
    end else if (w_shift < LP_MIN) begin
      w_sat = 32'h8000_0000;
    end
  end

  // The result is captured on the last MAC edge so it is ready in EMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_i         <= 16'h0;
      r_o         <= 16'h0;
      r_base      <= 16'h0;
      r_acc       <= 64'sh0;
      r_out_valid <= 1'b0;
      r_out_index <= 16'h0;
      r_out_data  <= 32'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i     <= 16'h0;
            r_o     <= 16'h0;
            r_base  <= 16'h0;
            r_acc   <= 64'sh0;
            r_busy  <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_i   <= r_i + 16'd1;
          if (r_i == LP_LAST_I) begin
            r_out_valid <= 1'b1;
            r_out_index <= r_o;
            r_out_data  <= w_sat;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          r_acc <= 64'sh0;
          r_i   <= 16'h0;
          if (r_o == LP_LAST_O) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_o     <= r_o + 16'd1;
            r_base  <= r_base + LP_STEP;
            r_state <= S_MAC;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_matvec_mac.sv
// Bench for matvec_mac: three parameterisations checked against
// a plain-arithmetic dot-product model with saturation.
`timescale 1ns/1ps
module tb_matvec_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat_shift(input longint acc,
                                            input int frac);
    longint sh;
    sh = acc >>> frac;
    if (sh > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (sh < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
    return sh[31:0];
  endfunction

  function automatic logic [31:0] rnd_s(input int bits);
    int v;
    v = int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
    return 32'(v);
  endfunction

  // ---------------- small instance: 4 x 2, integer ----------------
  logic        s_rst = 1'b1, s_start = 1'b0;
  logic [15:0] s_wa, s_ia, s_oi;
  logic [31:0] s_wd, s_id, s_od;
  logic        s_ov, s_busy, s_done;
  logic [31:0] s_w [8];
  logic [31:0] s_x [4];

  assign s_wd = (s_wa < 16'd8) ? s_w[s_wa[2:0]] : 32'h0;
  assign s_id = (s_ia < 16'd4) ? s_x[s_ia[1:0]] : 32'h0;

  matvec_mac #(.IN_DIM(4), .OUT_DIM(2), .FRAC_BITS(0)) u_s (
    .clk(clk), .reset(s_rst), .start(s_start),
    .weight_addr(s_wa), .weight_data(s_wd),
    .input_addr(s_ia), .input_data(s_id),
    .out_valid(s_ov), .out_index(s_oi), .out_data(s_od),
    .busy(s_busy), .done(s_done)
  );

  logic [47:0] s_q[$];
  int s_busy_n, s_done_n, s_both, s_last_ov, s_done_cyc;

  always @(negedge clk) begin
    if (!s_rst) begin
      if (s_ov) begin
        s_q.push_back({s_oi, s_od});
        s_last_ov = cyc;
      end
      if (s_done) begin
        s_done_n++;
        s_done_cyc = cyc;
      end
      if (s_busy) s_busy_n++;
      if (s_ov && s_done) s_both++;
    end
  end

  task automatic s_clear();
    s_q.delete();
    s_busy_n = 0;
    s_done_n = 0;
    s_both = 0;
  endtask

  task automatic s_wait(input int lim);
    int n = 0;
    while (s_done_n == 0 && n < lim) begin
      tick();
      n++;
    end
    chk("s_done_seen", 64'(s_done_n != 0), 64'd1);
  endtask

  task automatic s_pass();
    s_clear();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_wait(60);
    tick();
  endtask

  task automatic s_check(input string tag);
    chk({tag, "_count"}, 64'(s_q.size()), 64'd2);
    for (int r = 0; r < 2; r++) begin
      longint acc, a, b;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        a = $signed(s_w[r*4+k]);
        b = $signed(s_x[k]);
        acc += a * b;
      end
      if (s_q.size() > r) begin
        chk($sformatf("%s_idx%0d", tag, r), 64'(s_q[r][47:32]), 64'(r));
        chk($sformatf("%s_data%0d", tag, r), 64'(s_q[r][31:0]),
            64'(sat_shift(acc, 0)));
      end
    end
    chk({tag, "_both"}, 64'(s_both), 64'd0);
    chk({tag, "_dones"}, 64'(s_done_n), 64'd1);
  endtask

  // --------------- tiny instance: 1 x 3, Q16 ----------------------
  logic        t_rst = 1'b1, t_start = 1'b0;
  logic [15:0] t_wa, t_ia, t_oi;
  logic [31:0] t_wd, t_id, t_od;
  logic        t_ov, t_busy, t_done;
  logic [31:0] t_w [3];
  logic [31:0] t_x;

  assign t_wd = (t_wa < 16'd3) ? t_w[t_wa[1:0]] : 32'h0;
  assign t_id = (t_ia == 16'd0) ? t_x : 32'h0;

  matvec_mac #(.IN_DIM(1), .OUT_DIM(3), .FRAC_BITS(16)) u_t (
    .clk(clk), .reset(t_rst), .start(t_start),
    .weight_addr(t_wa), .weight_data(t_wd),
    .input_addr(t_ia), .input_data(t_id),
    .out_valid(t_ov), .out_index(t_oi), .out_data(t_od),
    .busy(t_busy), .done(t_done)
  );

  logic [47:0] t_q[$];
  int t_done_n;

  always @(negedge clk) begin
    if (!t_rst) begin
      if (t_ov) t_q.push_back({t_oi, t_od});
      if (t_done) t_done_n++;
    end
  end

  task automatic t_pass(input string tag);
    int n = 0;
    t_q.delete();
    t_done_n = 0;
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    while (t_done_n == 0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(t_done_n), 64'd1);
    chk({tag, "_count"}, 64'(t_q.size()), 64'd3);
    for (int r = 0; r < 3; r++) begin
      longint a, b;
      a = $signed(t_w[r]);
      b = $signed(t_x);
      if (t_q.size() > r) begin
        chk($sformatf("%s_idx%0d", tag, r), 64'(t_q[r][47:32]), 64'(r));
        chk($sformatf("%s_data%0d", tag, r), 64'(t_q[r][31:0]),
            64'(sat_shift(a * b, 16)));
      end
    end
    tick();
  endtask

  // --------------- default instance: 784 x 5, Q16 -----------------
  logic        d_rst = 1'b1, d_start = 1'b0;
  logic [15:0] d_wa, d_ia, d_oi;
  logic [31:0] d_wd, d_id, d_od;
  logic        d_ov, d_busy, d_done;
  logic [31:0] d_w [3920];
  logic [31:0] d_x [784];

  assign d_wd = (d_wa < 16'd3920) ? d_w[d_wa] : 32'h0;
  assign d_id = (d_ia < 16'd784) ? d_x[d_ia] : 32'h0;

  matvec_mac u_d (
    .clk(clk), .reset(d_rst), .start(d_start),
    .weight_addr(d_wa), .weight_data(d_wd),
    .input_addr(d_ia), .input_data(d_id),
    .out_valid(d_ov), .out_index(d_oi), .out_data(d_od),
    .busy(d_busy), .done(d_done)
  );

  logic [47:0] d_q[$];
  int d_done_n, d_busy_n, d_mac_n, d_werr, d_ierr, d_zerr, d_last_wa;

  // Every busy cycle that is neither EMIT nor DONE is a MAC cycle.
  always @(negedge clk) begin
    if (!d_rst) begin
      if (d_ov) d_q.push_back({d_oi, d_od});
      if (d_done) d_done_n++;
      if (d_busy) d_busy_n++;
      if (d_busy && !d_ov && !d_done) begin
        if (d_wa != 16'(d_mac_n)) d_werr++;
        if (d_ia != 16'(d_mac_n % 784)) d_ierr++;
        d_last_wa = int'(d_wa);
        d_mac_n++;
      end else if (d_wa != 16'h0 || d_ia != 16'h0) begin
        d_zerr++;
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) s_w[k] = 32'h0;
    for (int k = 0; k < 4; k++) s_x[k] = 32'h0;
    s_clear();
    t_done_n = 0;
    {d_done_n, d_busy_n, d_mac_n, d_werr, d_ierr, d_zerr} = '0;
    d_last_wa = 0;

    tick();
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_valid", 64'(s_ov), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_data", 64'(s_od), 64'd0);
    chk("rst_index", 64'(s_oi), 64'd0);
    chk("rst_waddr", 64'(s_wa), 64'd0);
    chk("rst_iaddr", 64'(s_ia), 64'd0);
    s_rst = 1'b0;
    t_rst = 1'b0;
    d_rst = 1'b0;
    repeat (3) tick();
    chk("idle_no_start", 64'(s_busy), 64'd0);

    // Unit weights, inputs 1..4.
    for (int k = 0; k < 8; k++) s_w[k] = 32'd1;
    for (int k = 0; k < 4; k++) s_x[k] = 32'(k + 1);
    s_pass();
    s_check("ones");
    if (s_q.size() == 2) begin
      chk("ones_d0", 64'(s_q[0][31:0]), 64'd10);
      chk("ones_d1", 64'(s_q[1][31:0]), 64'd10);
    end
    chk("ones_busy", 64'(s_busy_n), 64'd11);
    chk("ones_done_lag", 64'(s_done_cyc - s_last_ov), 64'd1);

    // Negative second row.
    for (int k = 4; k < 8; k++) s_w[k] = 32'hFFFF_FFFF;
    s_pass();
    s_check("neg");
    if (s_q.size() == 2) begin
      chk("neg_d0", 64'(s_q[0][31:0]), 64'h0000_000A);
      chk("neg_d1", 64'(s_q[1][31:0]), 64'hFFFF_FFF6);
    end

    // Random small values, then full-range values.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++)
        s_w[k] = (p == 2) ? $urandom : rnd_s(14);
      for (int k = 0; k < 4; k++)
        s_x[k] = (p == 2) ? $urandom : rnd_s(14);
      s_pass();
      s_check($sformatf("rnd%0d", p));
    end

    // Start held high across a whole pass.
    s_clear();
    s_start = 1'b1;
    s_wait(60);
    tick();
    chk("hold_idle_gap", 64'(s_busy), 64'd0);
    chk("hold_one_pass", 64'(s_q.size()), 64'd2);
    chk("hold_dones", 64'(s_done_n), 64'd1);
    tick();
    chk("hold_restart", 64'(s_busy), 64'd1);
    s_start = 1'b0;
    s_clear();
    s_wait(60);
    tick();
    s_check("hold2");

    // Reset pulse during row 1.
    s_clear();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int n = 0; n < 20 && s_q.size() == 0; n++) tick();
    tick();
    tick();
    #1 s_rst = 1'b1;
    #1;
    chk("arst_busy", 64'(s_busy), 64'd0);
    chk("arst_valid", 64'(s_ov), 64'd0);
    chk("arst_data", 64'(s_od), 64'd0);
    chk("arst_waddr", 64'(s_wa), 64'd0);
    tick();
    tick();
    s_rst = 1'b0;
    s_clear();
    repeat (12) tick();
    chk("arst_no_valid", 64'(s_q.size()), 64'd0);
    chk("arst_no_done", 64'(s_done_n), 64'd0);
    chk("arst_idle", 64'(s_busy), 64'd0);
    for (int k = 0; k < 8; k++) s_w[k] = rnd_s(16);
    for (int k = 0; k < 4; k++) s_x[k] = rnd_s(16);
    s_pass();
    s_check("after_rst");

    // Q16 saturation on the 1-wide instance.
    for (int k = 0; k < 3; k++) t_w[k] = 32'h7FFF_FFFF;
    t_x = 32'h7FFF_FFFF;
    t_pass("sat_hi");
    if (t_q.size() == 3) chk("sat_hi_lit", 64'(t_q[0][31:0]), 64'h7FFF_FFFF);
    t_x = 32'h8000_0000;
    t_pass("sat_lo");
    if (t_q.size() == 3) chk("sat_lo_lit", 64'(t_q[2][31:0]), 64'h8000_0000);
    t_w[0] = 32'h0001_0000;
    t_w[1] = 32'hFFFF_0000;
    t_w[2] = 32'h0000_8000;
    t_x = 32'h0002_8000;
    t_pass("q16");
    if (t_q.size() == 3) chk("q16_lit", 64'(t_q[1][31:0]), 64'hFFFD_8000);

    // Full default-size pass with random Q16 data.
    for (int k = 0; k < 3920; k++) d_w[k] = rnd_s(18);
    for (int k = 0; k < 784; k++) d_x[k] = rnd_s(18);
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int n = 0; n < 5000 && d_done_n == 0; n++) tick();
    chk("dflt_done", 64'(d_done_n), 64'd1);
    chk("dflt_count", 64'(d_q.size()), 64'd5);
    for (int r = 0; r < 5; r++) begin
      longint acc, a, b;
      acc = 0;
      for (int k = 0; k < 784; k++) begin
        a = $signed(d_w[r*784+k]);
        b = $signed(d_x[k]);
        acc += a * b;
      end
      if (d_q.size() > r) begin
        chk($sformatf("dflt_idx%0d", r), 64'(d_q[r][47:32]), 64'(r));
        chk($sformatf("dflt_data%0d", r), 64'(d_q[r][31:0]),
            64'(sat_shift(acc, 16)));
      end
    end
    chk("dflt_mac_cycles", 64'(d_mac_n), 64'd3920);
    chk("dflt_last_waddr", 64'(d_last_wa), 64'd3919);
    chk("dflt_waddr_seq", 64'(d_werr), 64'd0);
    chk("dflt_iaddr_seq", 64'(d_ierr), 64'd0);
    chk("dflt_addr_zero", 64'(d_zerr), 64'd0);
    chk("dflt_busy", 64'(d_busy_n), 64'd3926);
    tick();
    chk("dflt_idle", 64'(d_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matvec_mac.md
MATVEC_MAC -- requirements
Module: matvec_mac

Interface
REQ-001 Parameter IN_DIM, default 784: input-vector length, which is also the weight row length.
REQ-002 Parameter OUT_DIM, default 5: number of output neurons, which is also the number of weight rows.
REQ-003 Parameter FRAC_BITS, default 16: fixed-point fraction bits shared by weights, inputs and outputs.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: begin a full matrix-vector pass; sampled only in IDLE.
REQ-007 Port weight_addr, output, 16: word address into the weight matrix memory.
REQ-008 Port weight_data, input, 32: signed weight word, combinationally valid in the same cycle as weight_addr.
REQ-009 Port input_addr, output, 16: word address into the input-vector memory.
REQ-010 Port input_data, input, 32: signed input word, combinationally valid in the same cycle as input_addr.
REQ-011 Port out_valid, output, 1: one-cycle strobe marking out_data and out_index valid.
REQ-012 Port out_index, output, 16: output neuron number, 0..OUT_DIM-1.
REQ-013 Port out_data, output, 32: signed saturated neuron result.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse after the last output has been emitted.

Function
REQ-016 The block SHALL implement the FSM states IDLE, MAC, EMIT and DONE, held in registered state.
REQ-017 IDLE with start=1 SHALL clear the i counter, the o counter, the row base and acc, then move to MAC; start=0 SHALL leave the block in IDLE.
REQ-018 In MAC, weight_addr SHALL equal base+i and input_addr SHALL equal i, where base is a register advanced by IN_DIM per row; no multiplier is used for addressing.
REQ-019 Each MAC cycle SHALL perform acc <= acc + sext64(weight_data)*sext64(input_data) as a signed 64-bit operation, and acc wraps on overflow.
REQ-020 In MAC, i SHALL increment each cycle; the cycle in which i==IN_DIM-1 SHALL include that product and then move to EMIT.
REQ-021 EMIT SHALL hold for exactly 1 cycle with out_valid=1, out_index=o, and out_data=sat32(acc >>> FRAC_BITS) using arithmetic shift.
REQ-022 sat32 SHALL clamp values above 0x7FFFFFFF to 0x7FFFFFFF and values below 0x80000000 to 0x80000000.
REQ-023 EMIT SHALL clear acc and i; if o==OUT_DIM-1 the next state SHALL be DONE, otherwise o+1, base+IN_DIM, and return to MAC.
REQ-024 DONE SHALL last 1 cycle with done=1 and then move to IDLE; start is accepted again in the following IDLE cycle.
REQ-025 Outside MAC, weight_addr and input_addr SHALL be 0.
REQ-026 start SHALL be ignored while busy=1, with no restart and no effect on counters.
REQ-027 Latency: the first MAC cycle SHALL follow the start-accept edge; a pass SHALL take OUT_DIM*(IN_DIM+1)+1 cycles from leaving IDLE to returning to IDLE.
REQ-028 The final weight address SHALL be OUT_DIM*IN_DIM-1, which is 3919 at defaults; both address ports SHALL be 16 bits, truncated.
REQ-029 out_valid and done SHALL never be high in the same cycle, and out_valid SHALL pulse exactly OUT_DIM times per pass.

Reset
REQ-030 reset=1 SHALL immediately force state=IDLE, all counters, base and acc to 0, and out_valid=0, done=0, busy=0, out_data=0, out_index=0, independent of clk.
REQ-031 Reset asserted mid-pass SHALL abort the pass with no further out_valid or done; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-032 With IN_DIM=4, OUT_DIM=2, FRAC_BITS=0, all weights 1 and inputs 1,2,3,4, one start SHALL give out_data 10 at index 0 then 10 at index 1, done 1 cycle later, and 11 busy cycles in total.
REQ-033 With the same parameters, row-0 weights 1 and row-1 weights -1 SHALL give outputs 0x0000000A and 0xFFFFFFF6.
REQ-034 With FRAC_BITS=16 and all weights and inputs 0x7FFFFFFF, out_data SHALL be 0x7FFFFFFF; with all inputs 0x80000000 instead, out_data SHALL be 0x80000000.
REQ-035 At default parameters, weight_addr SHALL step 0..3919 contiguously across MAC cycles and input_addr SHALL repeat 0..783 five times; out_index SHALL run 0..4.
REQ-036 A reset pulse during row 1 of a pass, followed by a new start, SHALL leave no stale out_valid or done and produce correct results, with acc starting from 0.
REQ-037 start held high for the whole pass SHALL produce exactly one pass, with the next pass beginning only from the IDLE cycle after done.
